// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
//
// Instruction execution sequencer. It walks every instruction through FETCH,
// DECODE and then zero or more EXEC phases, and keeps doing so until the
// decoder raises halt. The number of execute phases for each instruction type
// comes from a packed lookup table parameter.
//
// Parameters
//   NUM_TYPES   number of instruction types (TYPE_W = clog2(NUM_TYPES))
//   MAX_PHASES  maximum execute phases per instruction (PH_W = clog2(MAX_PHASES+1))
//   PHASE_TABLE packed phase count per type, type t at [t*PH_W +: PH_W]
//   CNT_W       width of the retired-instruction counter
//
// Ports
//   clk          rising-edge clock
//   init_n       synchronous active-low reset
//   start        one-cycle request to begin execution
//   inst_type    decoded instruction type, sampled on the edge ending DECODE
//   halt         decoder halt flag, sampled with inst_type
//   stall        holds the current execute phase (only looked at in EXEC)
//   fetch_en     fetch-unit enable (FETCH)
//   decode_en    decoder enable (DECODE)
//   phase_en     one-hot execute-phase enable (EXEC)
//   inst_done    one-cycle pulse when an instruction retires
//   busy         high in FETCH, DECODE and EXEC
//   done         high in HALTED
//   bad_type     sticky illegal-type flag
//   retired      count of retired instructions (wraps silently)
//   dbg_state_o  current FSM state, for observation only
//
// Handshake: start is a single-cycle request with no ready. It is accepted on
// a rising edge only while the sequencer is IDLE or HALTED (busy=0); at any
// other time it is dropped without effect.
//
// Every output is a flop: each output register is loaded with the value that
// matches the state being entered, so outputs move only on rising clk.
// -----------------------------------------------------------------------------
module exec_sequencer #(
    parameter int NUM_TYPES  = 8,
    parameter int MAX_PHASES = 4,
    parameter logic [NUM_TYPES*$clog2(MAX_PHASES+1)-1:0] PHASE_TABLE =
        {3'd0, 3'd3, 3'd2, 3'd0, 3'd1, 3'd0, 3'd3, 3'd0},
    parameter int CNT_W      = 16
) (
    input  logic                                                   clk,
    input  logic                                                   init_n,
    input  logic                                                   start,
    input  logic [((NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1)-1:0]   inst_type,
    input  logic                                                   halt,
    input  logic                                                   stall,
    output logic                                                   fetch_en,
    output logic                                                   decode_en,
    output logic [MAX_PHASES-1:0]                                  phase_en,
    output logic                                                   inst_done,
    output logic                                                   busy,
    output logic                                                   done,
    output logic                                                   bad_type,
    output logic [CNT_W-1:0]                                       retired,
    output logic [2:0]                                             dbg_state_o
);

    localparam int TYPE_W = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1;
    localparam int PH_W   = $clog2(MAX_PHASES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [PH_W-1:0]       p_q, p_d;          // current execute phase index
    logic [PH_W-1:0]       n_q, n_d;          // phase count of the instruction in flight
    logic                  bad_q, bad_d;
    logic [CNT_W-1:0]      retired_q, retired_d;
    logic                  retire;

    logic                  fetch_q, fetch_d;
    logic                  decode_q, decode_d;
    logic [MAX_PHASES-1:0] phase_q, phase_d;
    logic                  inst_done_q, inst_done_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [PH_W-1:0]       lut_n;
    logic                  lut_bad;

    // Table lookup. A type outside the table, or an entry larger than
    // MAX_PHASES, is treated as a zero-phase instruction and flagged.
    always_comb begin
        lut_n   = '0;
        lut_bad = 1'b1;
        for (int t = 0; t < NUM_TYPES; t++) begin
            if (inst_type == TYPE_W'(t)) begin
                lut_n   = PHASE_TABLE[t*PH_W +: PH_W];
                lut_bad = 1'b0;
            end
        end
        if (lut_n > PH_W'(MAX_PHASES)) begin
            lut_n   = '0;
            lut_bad = 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        n_d       = n_q;
        bad_d     = bad_q;
        retired_d = retired_q;
        retire    = 1'b0;

        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d   = FETCH;
                    retired_d = '0;
                    bad_d     = 1'b0;
                end
            end
            FETCH: begin
                state_d = DECODE;
            end
            DECODE: begin
                if (halt) begin
                    state_d = HALTED;
                end else begin
                    bad_d = bad_q | lut_bad;
                    n_d   = lut_n;
                    p_d   = '0;
                    if (lut_n == '0) begin
                        // Nothing to execute: retire straight back into FETCH.
                        state_d = FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (!stall) begin
                    if (p_q == n_q - PH_W'(1)) begin
                        state_d = FETCH;
                        p_d     = '0;
                        retire  = 1'b1;
                    end else begin
                        p_d = p_q + PH_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                p_d     = '0;
            end
        endcase

        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // Output values for the state being entered. inst_done rides on the
    // transition into FETCH, so it coincides with the next fetch_en.
    always_comb begin
        fetch_d     = (state_d == FETCH);
        decode_d    = (state_d == DECODE);
        phase_d     = '0;
        if (state_d == EXEC) begin
            phase_d = MAX_PHASES'(1) << p_d;
        end
        inst_done_d = retire;
        busy_d      = (state_d == FETCH) || (state_d == DECODE) || (state_d == EXEC);
        done_d      = (state_d == HALTED);
    end

    always_ff @(posedge clk) begin
        if (!init_n) begin
            state_q     <= IDLE;
            p_q         <= '0;
            n_q         <= '0;
            bad_q       <= 1'b0;
            retired_q   <= '0;
            fetch_q     <= 1'b0;
            decode_q    <= 1'b0;
            phase_q     <= '0;
            inst_done_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            n_q         <= n_d;
            bad_q       <= bad_d;
            retired_q   <= retired_d;
            fetch_q     <= fetch_d;
            decode_q    <= decode_d;
            phase_q     <= phase_d;
            inst_done_q <= inst_done_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign fetch_en    = fetch_q;
    assign decode_en   = decode_q;
    assign phase_en    = phase_q;
    assign inst_done   = inst_done_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign bad_type    = bad_q;
    assign retired     = retired_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer. Two instances: dut_a with default parameters and
// dut_b with NUM_TYPES=6, CNT_W=4. Stimulus is shared except for the resets;
// the instance not under test is held in reset.
// Expected output snapshots are queued with the cycle they belong to; the
// monitor compares every queued entry when its cycle comes round.
module tb_exec_sequencer;

  localparam int W = 26;

  logic clk = 1'b0;
  logic init_n_a, init_n_b, start, halt, stall;
  logic [2:0] inst_type;

  logic fetch_en_a, decode_en_a, inst_done_a, busy_a, done_a, bad_type_a;
  logic [3:0] phase_en_a;
  logic [15:0] retired_a;
  logic [2:0] dbg_a;

  logic fetch_en_b, decode_en_b, inst_done_b, busy_b, done_b, bad_type_b;
  logic [3:0] phase_en_b;
  logic [3:0] retired_b;
  logic [2:0] dbg_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int exp_cyc_q[$];
  bit exp_sel_q[$];
  string exp_tag_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exec_sequencer dut_a (
    .clk(clk), .init_n(init_n_a), .start(start), .inst_type(inst_type),
    .halt(halt), .stall(stall), .fetch_en(fetch_en_a), .decode_en(decode_en_a),
    .phase_en(phase_en_a), .inst_done(inst_done_a), .busy(busy_a), .done(done_a),
    .bad_type(bad_type_a), .retired(retired_a), .dbg_state_o(dbg_a)
  );

  exec_sequencer #(
    .NUM_TYPES(6), .MAX_PHASES(4),
    .PHASE_TABLE({3'd2, 3'd0, 3'd1, 3'd0, 3'd3, 3'd0}),
    .CNT_W(4)
  ) dut_b (
    .clk(clk), .init_n(init_n_b), .start(start), .inst_type(inst_type),
    .halt(halt), .stall(stall), .fetch_en(fetch_en_b), .decode_en(decode_en_b),
    .phase_en(phase_en_b), .inst_done(inst_done_b), .busy(busy_b), .done(done_b),
    .bad_type(bad_type_b), .retired(retired_b), .dbg_state_o(dbg_b)
  );

  // ---------------- helpers / driver ----------------
  function automatic logic [W-1:0] v(bit f, bit d, logic [3:0] ph, bit id,
                                     bit bsy, bit dn, bit bad, logic [15:0] ret);
    return {f, d, ph, id, bsy, dn, bad, ret};
  endfunction

  task automatic expect_at(input bit sel, input int base, input int off,
                           input logic [W-1:0] val, input string tag);
    exp_q.push_back(val);
    exp_cyc_q.push_back(base + off);
    exp_sel_q.push_back(sel);
    exp_tag_q.push_back(tag);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic [W-1:0] act_a, act_b, act;
    int i;
    #1;
    act_a = {fetch_en_a, decode_en_a, phase_en_a, inst_done_a, busy_a, done_a,
             bad_type_a, retired_a};
    act_b = {fetch_en_b, decode_en_b, phase_en_b, inst_done_b, busy_b, done_b,
             bad_type_b, 12'd0, retired_b};
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_cyc_q[i] <= cyc) begin
        checks++;
        act = exp_sel_q[i] ? act_b : act_a;
        if (exp_cyc_q[i] < cyc) begin
          errors++;
          $display("FAIL %s dut=%0d missed cycle %0d exp=%h", exp_tag_q[i],
                   exp_sel_q[i], exp_cyc_q[i], exp_q[i]);
        end else if (act !== exp_q[i]) begin
          errors++;
          $display("FAIL %s dut=%0d cyc=%0d got=%h exp=%h", exp_tag_q[i],
                   exp_sel_q[i], cyc, act, exp_q[i]);
        end
        exp_q.delete(i);
        exp_cyc_q.delete(i);
        exp_sel_q.delete(i);
        exp_tag_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    init_n_a = 1'b0; init_n_b = 1'b0; start = 1'b0;
    halt = 1'b0; stall = 1'b0; inst_type = 3'd0;

    // Reset state of both instances, then A stays IDLE after release.
    @(negedge clk); @(negedge clk);
    c = cyc;
    expect_at(0, c, 1, v(0,0,4'h0,0,0,0,0,16'd0), "reset_a");
    expect_at(1, c, 1, v(0,0,4'h0,0,0,0,0,16'd0), "reset_b");
    init_n_a = 1'b1;
    stall = 1'b1;
    expect_at(0, c, 2, v(0,0,4'h0,0,0,0,0,16'd0), "idle_hold1");
    expect_at(0, c, 3, v(0,0,4'h0,0,0,0,0,16'd0), "idle_hold2");
    wait_cyc(c + 3);
    stall = 1'b0;

    // Type 1, N=3, no stall; then halt on the following decode.
    c = cyc;
    inst_type = 3'd1; halt = 1'b0; start = 1'b1;
    expect_at(0, c, 1, v(1,0,4'h0,0,1,0,0,16'd0), "t1_fetch");
    expect_at(0, c, 2, v(0,1,4'h0,0,1,0,0,16'd0), "t1_decode");
    expect_at(0, c, 3, v(0,0,4'h1,0,1,0,0,16'd0), "t1_ph0");
    expect_at(0, c, 4, v(0,0,4'h2,0,1,0,0,16'd0), "t1_ph1");
    expect_at(0, c, 5, v(0,0,4'h4,0,1,0,0,16'd0), "t1_ph2");
    expect_at(0, c, 6, v(1,0,4'h0,1,1,0,0,16'd1), "t1_retire");
    expect_at(0, c, 7, v(0,1,4'h0,0,1,0,0,16'd1), "t1_decode2");
    expect_at(0, c, 8, v(0,0,4'h0,0,0,1,0,16'd1), "t1_halted");
    expect_at(0, c, 9, v(0,0,4'h0,0,0,1,0,16'd1), "t1_halted_hold");
    wait_cyc(c + 1); start = 1'b0;
    wait_cyc(c + 6); halt = 1'b1;
    wait_cyc(c + 8); halt = 1'b0;
    wait_cyc(c + 9);

    // Restart from HALTED clears retired; type 2, N=0.
    c = cyc;
    inst_type = 3'd2; start = 1'b1;
    expect_at(0, c, 1, v(1,0,4'h0,0,1,0,0,16'd0), "t2_fetch_clr");
    expect_at(0, c, 2, v(0,1,4'h0,0,1,0,0,16'd0), "t2_decode");
    expect_at(0, c, 3, v(1,0,4'h0,1,1,0,0,16'd1), "t2_retire1");
    expect_at(0, c, 4, v(0,1,4'h0,0,1,0,0,16'd1), "t2_decode2");
    expect_at(0, c, 5, v(1,0,4'h0,1,1,0,0,16'd2), "t2_retire2");
    expect_at(0, c, 6, v(0,1,4'h0,0,1,0,0,16'd2), "t2_decode3");
    expect_at(0, c, 7, v(0,0,4'h0,0,0,1,0,16'd2), "t2_halted");
    wait_cyc(c + 1); start = 1'b0;
    wait_cyc(c + 5); halt = 1'b1;
    wait_cyc(c + 7); halt = 1'b0;
    wait_cyc(c + 8);

    // Type 6, N=3, stall held over three edges in phase 1.
    c = cyc;
    inst_type = 3'd6; start = 1'b1;
    expect_at(0, c, 1,  v(1,0,4'h0,0,1,0,0,16'd0), "t3_fetch");
    expect_at(0, c, 2,  v(0,1,4'h0,0,1,0,0,16'd0), "t3_decode");
    expect_at(0, c, 3,  v(0,0,4'h1,0,1,0,0,16'd0), "t3_ph0");
    expect_at(0, c, 4,  v(0,0,4'h2,0,1,0,0,16'd0), "t3_stall0");
    expect_at(0, c, 5,  v(0,0,4'h2,0,1,0,0,16'd0), "t3_stall1");
    expect_at(0, c, 6,  v(0,0,4'h2,0,1,0,0,16'd0), "t3_stall2");
    expect_at(0, c, 7,  v(0,0,4'h2,0,1,0,0,16'd0), "t3_stall3");
    expect_at(0, c, 8,  v(0,0,4'h4,0,1,0,0,16'd0), "t3_ph2");
    expect_at(0, c, 9,  v(1,0,4'h0,1,1,0,0,16'd1), "t3_retire");
    expect_at(0, c, 10, v(0,1,4'h0,0,1,0,0,16'd1), "t3_decode2");
    expect_at(0, c, 11, v(0,0,4'h0,0,0,1,0,16'd1), "t3_halted");
    wait_cyc(c + 1); start = 1'b0;
    wait_cyc(c + 4); stall = 1'b1;
    wait_cyc(c + 7); stall = 1'b0;
    wait_cyc(c + 9); halt = 1'b1;
    wait_cyc(c + 11); halt = 1'b0;
    wait_cyc(c + 12);

    // Reset in the middle of phase 2 of the second type-1 instruction.
    c = cyc;
    inst_type = 3'd1; start = 1'b1;
    expect_at(0, c, 1,  v(1,0,4'h0,0,1,0,0,16'd0), "t4_fetch");
    expect_at(0, c, 6,  v(1,0,4'h0,1,1,0,0,16'd1), "t4_retire");
    expect_at(0, c, 7,  v(0,1,4'h0,0,1,0,0,16'd1), "t4_decode2");
    expect_at(0, c, 8,  v(0,0,4'h1,0,1,0,0,16'd1), "t4_ph0");
    expect_at(0, c, 9,  v(0,0,4'h2,0,1,0,0,16'd1), "t4_ph1");
    expect_at(0, c, 10, v(0,0,4'h4,0,1,0,0,16'd1), "t4_ph2");
    expect_at(0, c, 11, v(0,0,4'h0,0,0,0,0,16'd0), "t4_reset");
    expect_at(0, c, 12, v(0,0,4'h0,0,0,0,0,16'd0), "t4_reset_hold");
    wait_cyc(c + 1); start = 1'b0;
    wait_cyc(c + 10); init_n_a = 1'b0;
    wait_cyc(c + 12); init_n_b = 1'b1;
    wait_cyc(c + 14);

    // dut_b: illegal type 7 sets the sticky flag; legal type keeps it set.
    c = cyc;
    inst_type = 3'd7; start = 1'b1;
    expect_at(1, c, 1, v(1,0,4'h0,0,1,0,0,16'd0), "t5_fetch");
    expect_at(1, c, 2, v(0,1,4'h0,0,1,0,0,16'd0), "t5_decode");
    expect_at(1, c, 3, v(1,0,4'h0,1,1,0,1,16'd1), "t5_bad_retire");
    expect_at(1, c, 4, v(0,1,4'h0,0,1,0,1,16'd1), "t5_decode2");
    expect_at(1, c, 5, v(1,0,4'h0,1,1,0,1,16'd2), "t5_bad_retire2");
    expect_at(1, c, 6, v(0,1,4'h0,0,1,0,1,16'd2), "t5_decode3");
    expect_at(1, c, 7, v(1,0,4'h0,1,1,0,1,16'd3), "t5_sticky");
    expect_at(1, c, 8, v(0,1,4'h0,0,1,0,1,16'd3), "t5_decode4");
    expect_at(1, c, 9, v(0,0,4'h0,0,0,1,1,16'd3), "t5_halted_sticky");
    wait_cyc(c + 1); start = 1'b0;
    wait_cyc(c + 5); inst_type = 3'd2;
    wait_cyc(c + 7); halt = 1'b1;
    wait_cyc(c + 9); halt = 1'b0;
    wait_cyc(c + 10);

    // dut_b: start clears bad_type; 17 N=0 instructions wrap the 4-bit count;
    // then reset during phase 2 of a type-1 instruction.
    c = cyc;
    inst_type = 3'd2; start = 1'b1;
    expect_at(1, c, 1,  v(1,0,4'h0,0,1,0,0,16'd0),  "t6_clear");
    expect_at(1, c, 3,  v(1,0,4'h0,1,1,0,0,16'd1),  "t6_ret1");
    expect_at(1, c, 31, v(1,0,4'h0,1,1,0,0,16'd15), "t6_ret15");
    expect_at(1, c, 33, v(1,0,4'h0,1,1,0,0,16'd0),  "t6_wrap");
    expect_at(1, c, 35, v(1,0,4'h0,1,1,0,0,16'd1),  "t6_ret17");
    expect_at(1, c, 36, v(0,1,4'h0,0,1,0,0,16'd1),  "t6_decode");
    expect_at(1, c, 37, v(0,0,4'h1,0,1,0,0,16'd1),  "t6_ph0");
    expect_at(1, c, 38, v(0,0,4'h2,0,1,0,0,16'd1),  "t6_ph1");
    expect_at(1, c, 39, v(0,0,4'h4,0,1,0,0,16'd1),  "t6_ph2");
    expect_at(1, c, 40, v(0,0,4'h0,0,0,0,0,16'd0),  "t6_reset");
    expect_at(0, c, 40, v(0,0,4'h0,0,0,0,0,16'd0),  "t6_a_in_reset");
    wait_cyc(c + 1); start = 1'b0;
    wait_cyc(c + 35); inst_type = 3'd1;
    wait_cyc(c + 39); init_n_b = 1'b0;
    wait_cyc(c + 42);

    // Drain with a bound; anything left over is a failed comparison.
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(negedge clk);
    while (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s dut=%0d never compared exp=%h", exp_tag_q[0],
               exp_sel_q[0], exp_q[0]);
      exp_q.delete(0);
      exp_cyc_q.delete(0);
      exp_sel_q.delete(0);
      exp_tag_q.delete(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
